// File: rtl/ws2812_strip_driver.sv
// rtl/ws2812_strip_driver.sv - WS2812 serialiser with on-chip frame buffer, brightness and colour order
module ws2812_strip_driver #(
    parameter int NUM_LEDS     = 50,
    parameter int BIT_CYC      = 15,
    parameter int T0H_CYC      = 4,
    parameter int T1H_CYC      = 9,
    parameter int RESET_CYC    = 960,
    parameter bit GRB_ORDER    = 1'b1,
    parameter bit AUTO_REFRESH = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb_data,
    input  logic [7:0]  led_num,
    input  logic        write,
    input  logic [7:0]  brightness,
    input  logic        update,
    output logic        data,
    output logic        busy,
    output logic        frame_done
);
    localparam int AW  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BCW = $clog2(BIT_CYC);
    localparam int GCW = (RESET_CYC > 2) ? $clog2(RESET_CYC) : 1;

    localparam logic [BCW-1:0] CNT_LAST = BCW'(BIT_CYC - 1);
    localparam logic [BCW-1:0] CNT_LOAD = BCW'(BIT_CYC - 2);
    localparam logic [BCW-1:0] T0H      = BCW'(T0H_CYC);
    localparam logic [BCW-1:0] T1H      = BCW'(T1H_CYC);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(RESET_CYC - 2);
    localparam logic [7:0]     IDX_LAST = 8'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        ST_LATCH,
        ST_WAIT,
        ST_LOAD,
        ST_SEND
    } state_t;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] m);
        return 8'(({9'd0, c} * {8'd0, m}) >> 8);
    endfunction

    logic [23:0] mem [NUM_LEDS];
    logic [23:0] rd_q;

    state_t           state_q, state_d;
    logic [GCW-1:0]   gap_q, gap_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       idx_q, idx_d;
    logic [23:0]      shift_q, shift_d;
    logic [7:0]       br_q, br_d;
    logic             pend_q, pend_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [8:0]       mult;
    logic [7:0]       r_s, g_s, b_s;
    logic [23:0]      word;

    always_ff @(posedge clk) begin
        if (write && ({1'b0, led_num} < 9'(NUM_LEDS))) begin
            mem[led_num[AW-1:0]] <= rgb_data;
        end
    end

    // Read address follows the next index so the word is ready during LOAD.
    always_ff @(posedge clk) begin
        rd_q <= mem[idx_d[AW-1:0]];
    end

    always_comb begin
        mult = (idx_q == 8'd0) ? ({1'b0, brightness} + 9'd1) : ({1'b0, br_q} + 9'd1);
        r_s  = scale(rd_q[23:16], mult);
        g_s  = scale(rd_q[15:8], mult);
        b_s  = scale(rd_q[7:0], mult);
        word = GRB_ORDER ? {g_s, r_s, b_s} : {r_s, g_s, b_s};
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        br_d      = br_q;
        pend_d    = pend_q;
        done_d    = 1'b0;

        if (!AUTO_REFRESH && update && (state_q != ST_WAIT)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_LATCH: begin
                // The following LOAD cycle supplies the final low cycle of the gap.
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (AUTO_REFRESH) begin
                        state_d = ST_LOAD;
                        idx_d   = 8'd0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (update || pend_q) begin
                    state_d = ST_LOAD;
                    idx_d   = 8'd0;
                    pend_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d   = ST_SEND;
                shift_d   = word;
                bit_cnt_d = '0;
                bit_idx_d = 5'd0;
                if (idx_q == 8'd0) begin
                    br_d = brightness;
                end
            end
            ST_SEND: begin
                if ((bit_idx_q == 5'd23) && (bit_cnt_q == CNT_LOAD) && (idx_q != IDX_LAST)) begin
                    state_d = ST_LOAD;
                    idx_d   = idx_q + 8'd1;
                end else if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 5'd23) begin
                        state_d = ST_LATCH;
                        gap_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                        shift_d   = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_LATCH;
        endcase

        data_d = (state_d == ST_SEND) && (bit_cnt_d < (shift_d[23] ? T1H : T0H));
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SEND) || done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LATCH;
            gap_q     <= '0;
            bit_cnt_q <= '0;
            bit_idx_q <= 5'd0;
            idx_q     <= 8'd0;
            shift_q   <= 24'd0;
            br_q      <= 8'd0;
            pend_q    <= 1'b0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            br_q      <= br_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign data       = data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// tb/tb_ws2812_strip_driver.sv - directed bench: default strip (auto refresh) and a small manual-update strip
module tb_ws2812_strip_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Default-parameter instance
    logic        reset_a = 1'b1, wr_a = 1'b0, upd_a = 1'b0;
    logic [23:0] rgb_a = '0;
    logic [7:0]  led_a = '0, br_a = 8'hFF;
    logic        data_a, busy_a, fd_a;

    ws2812_strip_driver u_auto (
        .clk(clk), .reset(reset_a), .rgb_data(rgb_a), .led_num(led_a), .write(wr_a),
        .brightness(br_a), .update(upd_a), .data(data_a), .busy(busy_a), .frame_done(fd_a)
    );

    // Small manual-update instance, RGB order
    logic        reset_b = 1'b1, wr_b = 1'b0, upd_b = 1'b0;
    logic [23:0] rgb_b = '0;
    logic [7:0]  led_b = '0, br_b = 8'hFF;
    logic        data_b, busy_b, fd_b;

    ws2812_strip_driver #(
        .NUM_LEDS(2), .BIT_CYC(6), .T0H_CYC(2), .T1H_CYC(4), .RESET_CYC(20),
        .GRB_ORDER(1'b0), .AUTO_REFRESH(1'b0)
    ) u_man (
        .clk(clk), .reset(reset_b), .rgb_data(rgb_b), .led_num(led_b), .write(wr_b),
        .brightness(br_b), .update(upd_b), .data(data_b), .busy(busy_b), .frame_done(fd_b)
    );

    // Line decoder for the default instance
    logic [23:0] model [50];
    logic [23:0] cap_a [50];
    logic [23:0] sh_a = '0;
    logic        prev_a = 1'b0;
    int hi_a = 0, lo_a = 1000, bit_a = 0, led_a_n = 0, frames_a = 0, bad_a = 0;
    int fd_cnt_a = 0, busy_bad_a = 0;
    int start_a [8];

    always @(negedge clk) begin
        if (data_a && !prev_a) begin
            if (lo_a > 100) begin
                if (frames_a < 8) start_a[frames_a] = cyc;
                frames_a++;
                bit_a = 0;
                led_a_n = 0;
            end else if (hi_a + lo_a != 15) begin
                bad_a++;
            end
            hi_a = 0;
        end
        if (!data_a && prev_a) begin
            if (hi_a == 9) sh_a = {sh_a[22:0], 1'b1};
            else begin
                if (hi_a != 4) bad_a++;
                sh_a = {sh_a[22:0], 1'b0};
            end
            bit_a++;
            if (bit_a == 24) begin
                if (led_a_n < 50) cap_a[led_a_n] = sh_a;
                led_a_n++;
                bit_a = 0;
            end
            lo_a = 0;
        end
        if (data_a) hi_a++; else lo_a++;
        if (fd_a) begin
            fd_cnt_a++;
            if (!busy_a) busy_bad_a++;
        end
        prev_a = data_a;
    end

    // Pulse counter for the manual instance
    logic prev_b = 1'b0;
    int hi_b = 0, rises_b = 0, ones_b = 0, first_hi_b = 0, fd_cnt_b = 0;

    always @(negedge clk) begin
        if (data_b && !prev_b) rises_b++;
        if (data_b) hi_b++;
        else if (prev_b) begin
            if (hi_b == 4) ones_b++;
            if (first_hi_b == 0) first_hi_b = hi_b;
            hi_b = 0;
        end
        if (fd_b) fd_cnt_b++;
        prev_b = data_b;
    end

    function automatic logic [23:0] exp_word(input logic [23:0] c, input logic [7:0] br);
        int m, r, g, b;
        m = int'(br) + 1;
        r = int'(c[23:16]) * m;
        g = int'(c[15:8]) * m;
        b = int'(c[7:0]) * m;
        return {8'(g >> 8), 8'(r >> 8), 8'(b >> 8)};
    endfunction

    task automatic write_a(input logic [7:0] n, input logic [23:0] v, input bit upd_model);
        led_a = n; rgb_a = v; wr_a = 1'b1;
        @(posedge clk); #1;
        wr_a = 1'b0;
        if (upd_model && n < 8'd50) model[n] = v;
    endtask

    task automatic write_b(input logic [7:0] n, input logic [23:0] v);
        led_b = n; rgb_b = v; wr_b = 1'b1;
        @(posedge clk); #1;
        wr_b = 1'b0;
    endtask

    task automatic pulse_upd_b();
        @(posedge clk); #1; upd_b = 1'b1;
        @(posedge clk); #1; upd_b = 1'b0;
    endtask

    task automatic wait_fd_a(input int target, input string tag);
        int n = 0;
        while (fd_cnt_a < target && n < 25000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(fd_cnt_a >= target), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_led_a(input int frame, input int led, input string tag);
        int n = 0;
        while (!(frames_a == frame && led_a_n >= led) && n < 25000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(frames_a == frame && led_a_n >= led), 32'd1);
    endtask

    task automatic measure_gap_a(input string tag);
        int n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (data_a) break;
            n++;
        end
        check(tag, n, 960);
    endtask

    task automatic check_frame_a(input string tag, input logic [7:0] br);
        int mism = 0;
        for (int i = 0; i < 50; i++) begin
            if (cap_a[i] !== exp_word(model[i], br)) mism++;
        end
        check(tag, mism, 0);
    endtask

    task automatic run_a();
        @(posedge clk); #1;
        for (int i = 0; i < 50; i++) begin
            write_a(8'(i), {8'(i * 5), 8'(255 - i), 8'(i * 3 + 7)}, 1'b1);
        end
        write_a(8'd0, 24'h102030, 1'b1);
        write_a(8'd1, 24'hFFFFFF, 1'b1);
        write_a(8'd49, 24'h800001, 1'b1);
        // The last write edge also sampled reset high
        reset_a = 1'b0;
        check("rst_data", data_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_fd", fd_a, 1'b0);
        measure_gap_a("gap_first");
        check("busy_in_frame", busy_a, 1'b1);

        wait_fd_a(1, "fd_frame1");
        check("f1_leds", led_a_n, 50);
        check("f1_led0", cap_a[0], 24'h201030);
        check("f1_led1", cap_a[1], 24'hFFFFFF);
        check("f1_led49", cap_a[49], 24'h008001);
        check("f1_bits", bad_a, 0);
        check_frame_a("f1_all", 8'hFF);
        check("gap_busy", busy_a, 1'b0);

        @(posedge clk); #1;
        br_a = 8'h7F;
        write_a(8'd0, 24'hFF8001, 1'b1);
        write_a(8'd50, 24'h123456, 1'b1);
        write_a(8'd255, 24'hABCDEF, 1'b1);
        wait_fd_a(2, "fd_frame2");
        check("f2_led0", cap_a[0], 24'h407F00);
        check("f2_led1", cap_a[1], 24'h7F7F7F);
        check("f2_bits", bad_a, 0);
        check_frame_a("f2_all", 8'h7F);
        check("f2_period", start_a[1] - start_a[0], 18960);

        wait_led_a(3, 3, "f3_reach_led3");
        repeat (30) @(negedge clk);
        @(posedge clk); #1;
        br_a = 8'hFF;
        write_a(8'd0, 24'h0A0B0C, 1'b0);
        write_a(8'd40, 24'hC0FFEE, 1'b1);
        wait_fd_a(3, "fd_frame3");
        check("f3_led0_old", cap_a[0], 24'h407F00);
        check("f3_led40_new", cap_a[40], 24'h7F6077);
        check_frame_a("f3_all", 8'h7F);
        check("f3_period", start_a[2] - start_a[1], 18960);
        model[0] = 24'h0A0B0C;

        wait_led_a(4, 10, "f4_reach_led10");
        check("f4_led0", cap_a[0], 24'h0B0A0C);
        check("f4_led9", cap_a[9], exp_word(model[9], 8'hFF));
        repeat (30) @(negedge clk);
        @(posedge clk); #1;
        reset_a = 1'b1;
        @(posedge clk); #1;
        reset_a = 1'b0;
        check("midrst_data", data_a, 1'b0);
        check("midrst_busy", busy_a, 1'b0);
        measure_gap_a("gap_after_rst");
        bad_a = 0;

        wait_fd_a(4, "fd_frame5");
        check("f5_leds", led_a_n, 50);
        check("f5_led0", cap_a[0], 24'h0B0A0C);
        check("f5_led40", cap_a[40], 24'hFFC0EE);
        check("f5_bits", bad_a, 0);
        check_frame_a("f5_all", 8'hFF);
        repeat (20) @(negedge clk);
        check("fd_count", fd_cnt_a, 4);
        check("fd_busy", busy_bad_a, 0);
    endtask

    task automatic run_b();
        int n = 0;
        @(posedge clk); #1;
        write_b(8'd0, 24'h800000);
        write_b(8'd1, 24'h000001);
        reset_b = 1'b0;
        repeat (500) @(negedge clk);
        check("man_idle_rises", rises_b, 0);
        check("man_idle_busy", busy_b, 1'b0);
        pulse_upd_b();
        while (!busy_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("man_start_busy", busy_b, 1'b1);
        repeat (40) @(negedge clk);
        pulse_upd_b();
        repeat (20) @(negedge clk);
        pulse_upd_b();
        repeat (1500) @(negedge clk);
        check("man_frames", fd_cnt_b, 2);
        check("man_bits", rises_b, 96);
        check("man_ones", ones_b, 4);
        check("man_rgb_first", first_hi_b, 4);
        check("man_end_busy", busy_b, 1'b0);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
